// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the
// IF/ID pipeline register, honouring stall, flush and redirects deferred across a stall.
module pc_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic                  jump_i,
    input  logic [DATA_WIDTH-1:0] jump_target_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    output logic [DATA_WIDTH-1:0] pc_plus_step_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_step_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic                  if_id_valid_o,
    output logic                  redirect_pending_o
);

    localparam logic [DATA_WIDTH-1:0] STEP_C = DATA_WIDTH'(PC_STEP);
    localparam logic [DATA_WIDTH-1:0] ZERO_C = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic [DATA_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic [DATA_WIDTH-1:0] ifid_step_q, ifid_step_d;
    logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic                  ifid_valid_q, ifid_valid_d;

    logic                  redirect_s;
    logic [DATA_WIDTH-1:0] target_s;
    logic [DATA_WIDTH-1:0] pc_next_seq_s;
    logic                  ifid_load_s;
    logic                  ifid_bubble_s;

    // Redirect source selection; a taken branch outranks a jump in the same cycle
    always_comb begin
        redirect_s    = branch_taken_i | jump_i;
        pc_next_seq_s = pc_q + STEP_C;
        if (branch_taken_i) begin
            target_s = branch_target_i;
        end else begin
            target_s = jump_target_i;
        end
    end

    // Next-state logic for PC, deferred target and IF/ID control
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        ifid_load_s   = 1'b0;
        ifid_bubble_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!stall_i) begin
                    if (redirect_s) begin
                        pc_d          = target_s;
                        ifid_bubble_s = 1'b1;
                    end else begin
                        pc_d = pc_next_seq_s;
                        if (flush_i) begin
                            ifid_bubble_s = 1'b1;
                        end else begin
                            ifid_load_s = 1'b1;
                        end
                    end
                end else begin
                    if (redirect_s) begin
                        pend_d  = target_s;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                    end
                    ifid_bubble_s = flush_i;
                end
            end
            ST_HOLD: begin
                // Only the first latched target survives; later redirects are dropped
                if (stall_i) begin
                    ifid_bubble_s = flush_i;
                end else begin
                    pc_d          = pend_q;
                    ifid_bubble_s = 1'b1;
                    state_d       = ST_RUN;
                end
            end
            default: begin
                state_d       = ST_RUN;
                ifid_bubble_s = 1'b1;
            end
        endcase
    end

    // IF/ID register next values: bubble, fresh fetch, or hold
    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_step_d  = ifid_step_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (ifid_bubble_s) begin
            ifid_pc_d    = ZERO_C;
            ifid_step_d  = ZERO_C;
            ifid_instr_d = ZERO_C;
            ifid_valid_d = 1'b0;
        end else if (ifid_load_s) begin
            ifid_pc_d    = pc_q;
            ifid_step_d  = pc_next_seq_s;
            ifid_instr_d = imem_data_i;
            ifid_valid_d = 1'b1;
        end else begin
            ifid_valid_d = ifid_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            pend_q       <= ZERO_C;
            ifid_pc_q    <= ZERO_C;
            ifid_step_q  <= ZERO_C;
            ifid_instr_q <= ZERO_C;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_step_q  <= ifid_step_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_addr_o        = pc_q;
    assign pc_plus_step_o     = pc_next_seq_s;
    assign if_id_pc_o         = ifid_pc_q;
    assign if_id_pc_step_o    = ifid_step_q;
    assign if_id_instr_o      = ifid_instr_q;
    assign if_id_valid_o      = ifid_valid_q;
    assign redirect_pending_o = (state_q == ST_HOLD);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a table of per-cycle stimulus with
// hand-computed post-edge expectations, checked through a scoreboard queue.
module tb_pc_fetch_unit;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, stall, flush, br, jmp;
    logic [31:0] bt, jt;
    logic [31:0] imem_addr, imem_data, pc_plus_step;
    logic [31:0] if_id_pc, if_id_pc_step, if_id_instr;
    logic        if_id_valid, pending;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst, stall, flush, br, jmp;
        logic [31:0] bt, jt;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ifpc;
        logic        e_pend;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    pc_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .branch_taken_i(br), .branch_target_i(bt), .jump_i(jmp), .jump_target_i(jt),
        .imem_addr_o(imem_addr), .imem_data_i(imem_data), .pc_plus_step_o(pc_plus_step),
        .if_id_pc_o(if_id_pc), .if_id_pc_step_o(if_id_pc_step), .if_id_instr_o(if_id_instr),
        .if_id_valid_o(if_id_valid), .redirect_pending_o(pending)
    );

    // instruction memory model: content derived from address
    assign imem_data = imem_addr ^ MAGIC;

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, s, f, b, input logic [31:0] bta,
                                input logic j, input logic [31:0] jta,
                                input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic epd);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.br = b; v.bt = bta; v.jmp = j; v.jt = jta;
        v.e_addr = ea; v.e_valid = ev; v.e_ifpc = ep; v.e_pend = epd;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check(input vec_t v);
        logic [31:0] e_step, e_instr;
        e_step  = v.e_valid ? (v.e_ifpc + 32'd4) : 32'd0;
        e_instr = v.e_valid ? (v.e_ifpc ^ MAGIC) : 32'd0;
        cmp("imem_addr",     imem_addr,            v.e_addr);
        cmp("pc_plus_step",  pc_plus_step,         v.e_addr + 32'd4);
        cmp("if_id_valid",   {31'd0, if_id_valid}, {31'd0, v.e_valid});
        cmp("if_id_pc",      if_id_pc,             v.e_valid ? v.e_ifpc : 32'd0);
        cmp("if_id_pc_step", if_id_pc_step,        e_step);
        cmp("if_id_instr",   if_id_instr,          e_instr);
        cmp("pending",       {31'd0, pending},     {31'd0, v.e_pend});
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; stall = v.stall; flush = v.flush;
        br = v.br; bt = v.bt; jmp = v.jmp; jt = v.jt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            check(sb.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0; jmp = 1'b0;
        bt = 32'd0; jt = 32'd0;

        //              rst   stl   fls   br    bt             jmp   jt             addr           v     ifpc           pend
        // reset and sequential fetch
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0));
        // branch at pc=0x10 to 0x40
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0,         32'h0000_0040, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0044, 1'b1, 32'h0000_0040, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0048, 1'b1, 32'h0000_0044, 1'b0));
        // deferred redirect: jump in stall cycle 1, branch in cycle 2 dropped
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0080, 32'h0000_0048, 1'b1, 32'h0000_0044, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         32'h0000_0048, 1'b1, 32'h0000_0044, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0048, 1'b1, 32'h0000_0044, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0080, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0084, 1'b1, 32'h0000_0080, 1'b0));
        // branch beats jump
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0300, 32'h0000_0100, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0104, 1'b1, 32'h0000_0100, 1'b0));
        // stall+flush bubbles IF/ID, pc holds; plain stall keeps the bubble
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0104, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0104, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0108, 1'b1, 32'h0000_0104, 1'b0));
        // flush without stall: bubble but pc advances
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_010C, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0110, 1'b1, 32'h0000_010C, 1'b0));
        // flush while pending; redirect on release cycle ignored
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0500, 32'h0000_0110, 1'b1, 32'h0000_010C, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0110, 1'b0, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0900, 32'h0000_0500, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0504, 1'b1, 32'h0000_0500, 1'b0));
        // wrap at top of address space
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0));
        // reset while pending discards the latched target
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0700, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0700, 32'h0000_0000, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0));

        foreach (vecs[i]) apply(vecs[i]);

        // long stall: first jump kept, later branch and jump dropped
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0));
        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0A00, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b1));
        for (int k = 0; k < 4; k++) begin
            apply(mk(1'b0, 1'b1, 1'b0, k[0], 32'h0000_0B00, ~k[0], 32'h0000_0C00,
                     32'h0000_0008, 1'b1, 32'h0000_0004, 1'b1));
        end
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0A00, 1'b0, 32'h0, 1'b0));
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0A04, 1'b1, 32'h0000_0A00, 1'b0));

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
